// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and master index.
package godai_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } arb_state_e;

  typedef logic master_idx_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of both master ports and the memory port seen by data_mem_arbiter.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic                  m0_req_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic                  m0_we_i;
  logic [BE_W-1:0]       m0_be_i;
  logic [DATA_WIDTH-1:0] m0_wdata_i;
  logic                  m0_gnt_o;
  logic                  m0_rvalid_o;
  logic [DATA_WIDTH-1:0] m0_rdata_o;
  logic                  m0_err_o;

  logic                  m1_req_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic                  m1_we_i;
  logic [BE_W-1:0]       m1_be_i;
  logic [DATA_WIDTH-1:0] m1_wdata_i;
  logic                  m1_gnt_o;
  logic                  m1_rvalid_o;
  logic [DATA_WIDTH-1:0] m1_rdata_o;
  logic                  m1_err_o;

  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [BE_W-1:0]       mem_be_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_err_i;

  // Arbiter side.
  modport slave (
    input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  // Environment side: requesting masters plus the memory.
  modport master (
    output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master not granted last.
module rr_arb2
  import godai_mem_pkg::*;
(
  input  logic [1:0]  req,
  input  master_idx_t last,
  output logic        valid,
  output master_idx_t idx
);

  always_comb begin
    valid = |req;
    idx   = master_idx_t'(req[1]);
    if (req == 2'b11) begin
      idx = ~last;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter between two masters onto a single data_memory port,
// with one outstanding transaction and a response timeout.
module data_mem_arbiter
  import godai_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e            state, state_nxt;
  master_idx_t           sel, last;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [BE_W-1:0]       be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]      tmo_cnt;

  logic                  pick_valid;
  master_idx_t           pick_idx;
  logic                  capture, granted, resp, resp_tmo, mem_req;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_we;
  logic [BE_W-1:0]       cap_be;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;

  rr_arb2 u_rr_arb2 (
    .req   ({bus.m1_req_i, bus.m0_req_i}),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Payload of whichever master the round-robin picked this cycle.
  always_comb begin
    cap_addr  = pick_idx ? bus.m1_addr_i  : bus.m0_addr_i;
    cap_we    = pick_idx ? bus.m1_we_i    : bus.m0_we_i;
    cap_be    = pick_idx ? bus.m1_be_i    : bus.m0_be_i;
    cap_wdata = pick_idx ? bus.m1_wdata_i : bus.m0_wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake strobes; everything is held quiet while in reset.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    granted   = 1'b0;
    resp      = 1'b0;
    resp_tmo  = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            capture   = 1'b1;
            state_nxt = REQ;
          end
        end
        REQ: begin
          if (bus.mem_gnt_i) begin
            granted   = 1'b1;
            state_nxt = RESP;
          end
        end
        RESP: begin
          if (bus.mem_rvalid_i) begin
            resp      = 1'b1;
            state_nxt = IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            resp      = 1'b1;
            resp_tmo  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    mem_req   = (state == REQ) && !rst;
    resp_data = resp_tmo ? '0 : bus.mem_rdata_i;
    resp_err  = resp_tmo | bus.mem_err_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= 1'b0;
      last    <= 1'b1;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      tmo_cnt <= '0;
    end else begin
      if (capture) begin
        sel     <= pick_idx;
        addr_q  <= cap_addr;
        we_q    <= cap_we;
        be_q    <= cap_be;
        wdata_q <= cap_wdata;
      end
      if (granted) begin
        last    <= sel;
        tmo_cnt <= '0;
      end else if (state == RESP) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_be_o    = be_q;
  assign bus.mem_wdata_o = wdata_q;

  // Responses are steered to the owner only; the other master sees zeros.
  assign bus.m0_gnt_o    = granted & (sel == 1'b0);
  assign bus.m1_gnt_o    = granted & (sel == 1'b1);
  assign bus.m0_rvalid_o = resp & (sel == 1'b0);
  assign bus.m1_rvalid_o = resp & (sel == 1'b1);
  assign bus.m0_err_o    = resp & (sel == 1'b0) & resp_err;
  assign bus.m1_err_o    = resp & (sel == 1'b1) & resp_err;
  assign bus.m0_rdata_o  = (resp && sel == 1'b0) ? resp_data : '0;
  assign bus.m1_rdata_o  = (resp && sel == 1'b1) ? resp_data : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: a word-array memory stub on the port and a
// transaction-level reference model (round-robin order, memory contents, timeout rule).
module tb_data_mem_arbiter;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = DW / 8;
  localparam int          TMO = 8;
  localparam logic [DW-1:0] WR_RESP = 32'h1111_1111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic          req   [2];
  logic [AW-1:0] addr  [2];
  logic          we    [2];
  logic [BW-1:0] be    [2];
  logic [DW-1:0] wdata [2];
  logic          mem_gnt, mem_rvalid, mem_err;
  logic [DW-1:0] mem_rdata;
  logic          gnt [2], rv [2], errv [2];
  logic [DW-1:0] rdat [2];

  assign bus.m0_req_i   = req[0];
  assign bus.m0_addr_i  = addr[0];
  assign bus.m0_we_i    = we[0];
  assign bus.m0_be_i    = be[0];
  assign bus.m0_wdata_i = wdata[0];
  assign bus.m1_req_i   = req[1];
  assign bus.m1_addr_i  = addr[1];
  assign bus.m1_we_i    = we[1];
  assign bus.m1_be_i    = be[1];
  assign bus.m1_wdata_i = wdata[1];
  assign bus.mem_gnt_i    = mem_gnt;
  assign bus.mem_rvalid_i = mem_rvalid;
  assign bus.mem_rdata_i  = mem_rdata;
  assign bus.mem_err_i    = mem_err;
  assign gnt[0]  = bus.m0_gnt_o;
  assign gnt[1]  = bus.m1_gnt_o;
  assign rv[0]   = bus.m0_rvalid_o;
  assign rv[1]   = bus.m1_rvalid_o;
  assign errv[0] = bus.m0_err_o;
  assign errv[1] = bus.m1_err_o;
  assign rdat[0] = bus.m0_rdata_o;
  assign rdat[1] = bus.m1_rdata_o;

  logic [DW-1:0] ref_mem  [64];
  logic [DW-1:0] stub_mem [64];
  bit            last_ref;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [BW-1:0] b);
    merge = old;
    for (int i = 0; i < int'(BW); i++) if (b[i]) merge[8*i +: 8] = d[8*i +: 8];
  endfunction

  task automatic rand_payload(input int m);
    addr[m]  = AW'($urandom);
    we[m]    = 1'($urandom_range(0, 1));
    be[m]    = BW'($urandom_range(1, 15));
    wdata[m] = $urandom;
  endtask

  // One full transaction from IDLE: grant after gd wait cycles, memory answers rd
  // cycles into RESP (or never); returns which master the DUT actually granted.
  task automatic serve_one(input int gd, input int rd, input bit no_rv, input bit err_in,
                           output int got);
    int w, idx, s_idx, resp_k;
    bit tmo, s_we;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wdata, e_rdata, s_rdata;
    got = -1;
    #1;
    check("idle_mem_req", 64'(bus.mem_req_o), 64'(0));
    w = (req[0] && req[1]) ? (last_ref ? 0 : 1) : (req[1] ? 1 : 0);
    e_addr = addr[w]; e_we = we[w]; e_be = be[w]; e_wdata = wdata[w];
    idx = int'(e_addr[AW-1:2]);
    e_rdata = e_we ? WR_RESP : ref_mem[idx];
    if (e_we) ref_mem[idx] = merge(ref_mem[idx], e_wdata, e_be);
    @(negedge clk); #1;
    check("mem_req", 64'(bus.mem_req_o), 64'(1));
    check("mem_addr", 64'(bus.mem_addr_o), 64'(e_addr));
    check("mem_we", 64'(bus.mem_we_o), 64'(e_we));
    check("mem_be", 64'(bus.mem_be_o), 64'(e_be));
    check("mem_wdata", 64'(bus.mem_wdata_o), 64'(e_wdata));
    repeat (gd) begin
      check("gnt_early", 64'(gnt[0] | gnt[1]), 64'(0));
      @(negedge clk); #1;
    end
    mem_gnt = 1'b1;
    #1;
    got = gnt[1] ? 1 : (gnt[0] ? 0 : -1);
    check("gnt_owner", 64'(gnt[w]), 64'(1));
    check("gnt_other", 64'(gnt[1-w]), 64'(0));
    s_idx = int'(bus.mem_addr_o[AW-1:2]);
    s_we  = bus.mem_we_o;
    if (s_we) stub_mem[s_idx] = merge(stub_mem[s_idx], bus.mem_wdata_o, bus.mem_be_o);
    s_rdata = s_we ? WR_RESP : stub_mem[s_idx];
    @(negedge clk);
    mem_gnt  = 1'b0;
    req[w]   = 1'b0;
    rand_payload(w);
    last_ref = (w == 1);
    tmo    = no_rv || (rd + 1 > TMO);
    resp_k = tmo ? TMO : rd + 1;
    for (int k = 1; k <= resp_k; k++) begin
      mem_gnt    = 1'($urandom_range(0, 1));
      mem_rvalid = !tmo && (k == resp_k);
      mem_rdata  = mem_rvalid ? s_rdata : $urandom;
      mem_err    = mem_rvalid ? err_in : 1'($urandom_range(0, 1));
      #1;
      if (k == 1) begin
        check("resp_mem_req", 64'(bus.mem_req_o), 64'(0));
        check("payload_hold", 64'(bus.mem_addr_o), 64'(e_addr));
      end
      if (k < resp_k) begin
        check("rv_early", 64'(rv[0] | rv[1] | gnt[0] | gnt[1]), 64'(0));
        check("rdata_quiet", 64'(rdat[0] | rdat[1]), 64'(0));
      end else begin
        check("rv_owner", 64'(rv[w]), 64'(1));
        check("err_owner", 64'(errv[w]), tmo ? 64'(1) : 64'(err_in));
        check("rdata_owner", 64'(rdat[w]), tmo ? 64'(0) : 64'(e_rdata));
        check("other_quiet", 64'({rv[1-w], errv[1-w], rdat[1-w]}), 64'(0));
      end
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int got;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[0]  = 32'hB000_B1E5;
    ref_mem[1]  = 32'hB001_1111;
    ref_mem[32] = 32'h3333_3333;
    stub_mem = ref_mem;
    last_ref = 1'b1;

    // Reset with busy-looking inputs: every output must stay low.
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin rand_payload(m); req[m] = 1'b1; end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = $urandom;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
    check("rst_gnt", 64'({gnt[0], gnt[1]}), 64'(0));
    check("rst_rv_err", 64'({rv[0], rv[1], errv[0], errv[1]}), 64'(0));
    check("rst_rdata", 64'(rdat[0] | rdat[1]), 64'(0));
    check("rst_mem_bus", 64'({bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o}), 64'(0));
    @(negedge clk);
    rst = 1'b0; req[0] = 1'b0; req[1] = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    @(negedge clk); #1;
    check("post_rst_idle", 64'(bus.mem_req_o), 64'(0));

    // Directed reads and a partial write.
    rand_payload(0); addr[0] = 8'h00; we[0] = 1'b0; req[0] = 1'b1;
    serve_one(1, 2, 1'b0, 1'b0, got);
    check("m0_read_who", 64'(got), 64'(0));
    rand_payload(1); addr[1] = 8'h80; we[1] = 1'b0; req[1] = 1'b1;
    serve_one(0, 0, 1'b0, 1'b0, got);
    rand_payload(0); addr[0] = 8'h04; we[0] = 1'b1; be[0] = 4'b0011; wdata[0] = 32'hDEAD_BEEF;
    req[0] = 1'b1;
    serve_one(0, 1, 1'b0, 1'b0, got);
    rand_payload(0); addr[0] = 8'h04; we[0] = 1'b0; req[0] = 1'b1;
    serve_one(2, 3, 1'b0, 1'b0, got);
    check("rmw_model", 64'(ref_mem[1]), 64'(32'hB001_BEEF));

    // Silent memory, then a late rvalid that must be dropped.
    rand_payload(0); addr[0] = 8'h20; we[0] = 1'b0; req[0] = 1'b1;
    serve_one(0, 0, 1'b1, 1'b0, got);
    mem_rvalid = 1'b1; mem_rdata = $urandom;
    #1;
    check("late_rvalid", 64'({rv[0], rv[1], errv[0], errv[1]}), 64'(0));
    @(negedge clk);
    mem_rvalid = 1'b0;
    // Memory answers in the final cycle (wins) and one cycle before it.
    rand_payload(0); we[0] = 1'b0; req[0] = 1'b1;
    serve_one(1, TMO - 1, 1'b0, 1'b1, got);
    rand_payload(1); req[1] = 1'b1;
    serve_one(0, TMO - 2, 1'b0, 1'b0, got);

    // Reset while waiting for the response.
    rand_payload(0); addr[0] = 8'h10; we[0] = 1'b0; req[0] = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    check("rst_txn_gnt", 64'(gnt[0]), 64'(1));
    @(negedge clk);
    mem_gnt = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
    #1;
    check("rst_resp_drop", 64'({rv[0], rv[1], bus.mem_req_o}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_late_drop", 64'({rv[0], rv[1], errv[0], bus.mem_req_o}), 64'(0));
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    last_ref = 1'b1;
    rand_payload(1); addr[1] = 8'h00; we[1] = 1'b0; req[1] = 1'b1;
    serve_one(0, 1, 1'b0, 1'b0, got);
    check("rst_recover_who", 64'(got), 64'(1));

    // Simultaneous requests, three each: strict alternation starting with m0.
    for (int m = 0; m < 2; m++) begin rand_payload(m); req[m] = 1'b1; end
    for (int i = 0; i < 6; i++) begin
      serve_one($urandom_range(0, 2), $urandom_range(0, 4), 1'b0, 1'b0, got);
      check("arb_order", 64'(got), 64'(i % 2));
      if (i < 4) begin rand_payload(i % 2); req[i % 2] = 1'b1; end
    end

    // Random traffic, including timeouts when rd runs past the limit.
    for (int it = 0; it < 40; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && $urandom_range(0, 2) != 0) begin rand_payload(m); req[m] = 1'b1; end
      end
      if (!req[0] && !req[1]) begin rand_payload(0); req[0] = 1'b1; end
      serve_one($urandom_range(0, 3), $urandom_range(0, 10), 1'b0,
                ($urandom_range(0, 7) == 0), got);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-master arbiter feeding the single request/grant/rvalid port of `data_memory`. Master 0 is the core load-store unit; master 1 is the trace/debug data port. The block selects one master round-robin, registers its request, and drives it onto the memory port until granted. It then routes the memory response back to the owning master, and raises an error response if the memory fails to answer within a bounded number of cycles.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: byte-address width; matches `data_memory`.
- `DATA_WIDTH`, default 32: data width; byte enables are `DATA_WIDTH/8` bits wide.
- `TIMEOUT`, default 64: maximum number of cycles spent in RESP before an error response is forced; must be ≥1.

Ports (`N` ∈ {0,1}):
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `mN_req_i` in 1: master N request; held, with its payload stable, until `mN_gnt_o`.
- `mN_addr_i` in ADDR_WIDTH: master N byte address.
- `mN_we_i` in 1: master N write enable (1 = write, 0 = read).
- `mN_be_i` in DATA_WIDTH/8: master N byte enables.
- `mN_wdata_i` in DATA_WIDTH: master N write data.
- `mN_gnt_o` out 1: one-cycle grant pulse to master N.
- `mN_rvalid_o` out 1: one-cycle response-valid pulse to master N.
- `mN_rdata_o` out DATA_WIDTH: response data to master N.
- `mN_err_o` out 1: error flag to master N; valid only with `mN_rvalid_o`.
- `mem_req_o` out 1: memory request.
- `mem_addr_o` out ADDR_WIDTH: memory address.
- `mem_we_o` out 1: memory write enable.
- `mem_be_o` out DATA_WIDTH/8: memory byte enables.
- `mem_wdata_o` out DATA_WIDTH: memory write data.
- `mem_gnt_i` in 1: memory grant.
- `mem_rvalid_i` in 1: memory response valid.
- `mem_rdata_i` in DATA_WIDTH: memory response data.
- `mem_err_i` in 1: memory error.

## Operation
- State machine with states IDLE, REQ and RESP. Registers:
  - `sel` (1 bit): master that owns the current transaction.
  - `last` (1 bit): master granted most recently.
  - payload registers for address, write enable, byte enables and write data.
  - `tmo_cnt`, `$clog2(TIMEOUT+1)` bits wide.
- IDLE:
  - If exactly one `mN_req_i` is high, select that master.
  - If both are high, select `!last`.
  - On selection: capture the selected master's payload, set `sel`, go to REQ.
  - With no request, stay in IDLE.
- REQ:
  - `mem_req_o`=1; `mem_*` outputs are driven from the payload registers.
  - On `mem_gnt_i`: `m[sel]_gnt_o`=1 in the same cycle (combinational), `last`←`sel`, `tmo_cnt`←0, go to RESP.
  - REQ has no timeout.
- RESP:
  - `mem_req_o`=0; `tmo_cnt` increments each cycle.
  - On `mem_rvalid_i`:
    - `m[sel]_rvalid_o`=1 in the same cycle.
    - `m[sel]_rdata_o`=`mem_rdata_i`.
    - `m[sel]_err_o`=`mem_err_i`.
    - Go to IDLE.
  - Else, when `tmo_cnt`==TIMEOUT-1:
    - `m[sel]_rvalid_o`=1, `m[sel]_err_o`=1, `m[sel]_rdata_o`=0.
    - Go to IDLE.
- `mem_gnt_i` and `mem_rvalid_i` are ignored in any state other than the one that consumes them. A late `mem_rvalid_i` after a timeout is dropped and not forwarded.
- The non-selected master sees gnt, rvalid and err all at 0. Its `rdata_o` is 0.
- Only one transaction is outstanding at a time.

## Timing
- Reset:
  - State←IDLE, `last`←1 so master 0 wins the first tie, `sel`←0, `tmo_cnt`←0, payload←0.
  - All outputs are 0 during and after reset until a request is seen.
- Reset in REQ or RESP abandons the transaction: `mem_req_o` is 0 from the next cycle, no response is sent to the master, and a subsequent memory rvalid is ignored.
- Latency:
  - Request seen in IDLE at cycle t → `mem_req_o`=1 at t+1.
  - Master grant in the same cycle as `mem_gnt_i`.
  - Response in the same cycle as `mem_rvalid_i`.
- Back-to-back: after a response, one IDLE cycle passes before the next arbitration. A master must deassert or renew `req` after its grant; a still-high `req` in IDLE is treated as a new request.
- Payload is captured once in IDLE. Changes on `mN_*_i` after capture do not affect `mem_*_o`.
- Timeout response occurs exactly TIMEOUT cycles after the grant cycle. If `mem_rvalid_i` arrives in that same final cycle, the memory response wins and err=`mem_err_i`.

## Structure
- Package `godai_mem_pkg` holds:
  - `arb_state_e` enum with IDLE=2'b00, REQ=2'b01, RESP=2'b10.
  - `master_idx_t`, a 1-bit typedef.
- Sub-module `rr_arb2`: combinational two-way round-robin pick. Inputs are `req[1:0]` and `last`; outputs are `valid` and `idx`.

## Test plan
All scenarios run with `data_memory` attached to the memory port.
- m0 reads addr 0x00 → `m0_gnt_o` pulses once; `m0_rvalid_o` pulses with rdata 0xB000B1E5, err 0; m1 outputs stay 0.
- m1 reads addr 0x80 → rdata 0x33333333 on `m1_rvalid_o`.
- m0 writes 0xDEADBEEF to 0x04 with be=4'b0011, then reads 0x04 → the write response carries 0x11111111; the read returns 0xB001BEEF.
- m0 and m1 request in the same cycle, three times each → grant order m0, m1, m0, m1, m0, m1.
- Memory stub never asserts rvalid, TIMEOUT=8 → `m0_rvalid_o` and `m0_err_o` pulse exactly 8 cycles after the grant; a later injected rvalid is not forwarded.
- `rst` asserted while in RESP → outputs 0; the pending response is dropped; the next m1 read of 0x00 completes normally with 0xB000B1E5.
